operand_loader: RTL and testbench

- Write-side counterpart of the matmul read-address controller.
- Accepts a row-major element stream for matrix A, then matrix B, over a valid/ready handshake.
- Writes each element into N-banked A/B operand memories, in the exact bank/address layout the read controller later sweeps.
- Sits between the host/DMA stream and the A/B operand RAMs; pulses load_done when both matrices are resident.

---
 rtl/matmul_pkg.sv | 10 +
 rtl/bank_addr_gen.sv | 48 ++++
 rtl/operand_loader.sv | 88 ++++++++
 tb/tb_operand_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared matmul defaults (N, M, DATA_W), per-bank address width helper aw_f, loader state enum
package matmul_pkg;
  localparam int N_DEF = 3;
  localparam int M_DEF = 6;
  localparam int DATA_W_DEF = 8;
  function automatic int aw_f(input int n, input int m);
    return $clog2((m * m) / n);
  endfunction
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} load_state_t;
endpackage

// File: rtl/bank_addr_gen.sv
// bank_addr_gen: bank/slice/pixel wrap counters (ports: clk rst clr adv -> bank_oh addr last); BANK_FAST=0 pixel fastest, =1 bank fastest
module bank_addr_gen
  import matmul_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter bit BANK_FAST = 1'b0,
  parameter int AW = aw_f(N, M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [N-1:0]  bank_oh,
  output logic [AW-1:0] addr,
  output logic          last
);
  localparam int S = M / N;
  localparam int BW = N > 1 ? $clog2(N) : 1;
  localparam int SW = S > 1 ? $clog2(S) : 1;
  localparam int PW = M > 1 ? $clog2(M) : 1;
  logic [BW-1:0] bank;
  logic [SW-1:0] slice;
  logic [PW-1:0] pix;
  logic bank_w, slice_w, pix_w, bank_inc, slice_inc, pix_inc;
  always_comb begin
    bank_w = bank == BW'(N - 1);
    slice_w = slice == SW'(S - 1);
    pix_w = pix == PW'(M - 1);
    pix_inc = BANK_FAST ? adv && bank_w && slice_w : adv;
    bank_inc = BANK_FAST ? adv : adv && pix_w;
    slice_inc = BANK_FAST ? adv && bank_w : adv && pix_w && bank_w;
    last = bank_w && slice_w && pix_w;
    bank_oh = N'(1) << bank;
    addr = AW'(int'(slice) * M + int'(pix));
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bank <= '0;
      slice <= '0;
      pix <= '0;
    end else begin
      if (bank_inc) bank <= bank_w ? '0 : bank + 1'b1;
      if (slice_inc) slice <= slice_w ? '0 : slice + 1'b1;
      if (pix_inc) pix <= pix_w ? '0 : pix + 1'b1;
    end
  end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: loads A then B row-major streams into N-banked operand RAMs (ports: clk rst start in_data/in_valid/in_last -> in_ready wr_*_A wr_*_B busy load_done load_err; LOADER_LAST_CHECK_EN enables the in_last framing check)
module operand_loader
  import matmul_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int AW = aw_f(N, M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [N-1:0]      wr_en_A,
  output logic [AW-1:0]     wr_addr_A,
  output logic [DATA_W-1:0] wr_data_A,
  output logic [N-1:0]      wr_en_B,
  output logic [AW-1:0]     wr_addr_B,
  output logic [DATA_W-1:0] wr_data_B,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);
  load_state_t state;
  logic hs, hs_a, hs_b, last_a, last_b;
  logic [N-1:0] oh_a, oh_b;
  logic [AW-1:0] addr_a, addr_b;
  always_comb begin
    in_ready = state == LOAD_A || state == LOAD_B;
    busy = in_ready;
    hs = in_valid && in_ready;
    hs_a = hs && state == LOAD_A;
    hs_b = hs && state == LOAD_B;
  end
  bank_addr_gen #(.N(N), .M(M), .BANK_FAST(1'b0), .AW(AW)) u_gen_a (
    .clk(clk), .rst(rst), .clr(state != LOAD_A), .adv(hs_a),
    .bank_oh(oh_a), .addr(addr_a), .last(last_a)
  );
  bank_addr_gen #(.N(N), .M(M), .BANK_FAST(1'b1), .AW(AW)) u_gen_b (
    .clk(clk), .rst(rst), .clr(state != LOAD_B), .adv(hs_b),
    .bank_oh(oh_b), .addr(addr_b), .last(last_b)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state == IDLE   ? (start ? LOAD_A : IDLE)
                : state == LOAD_A ? (hs && last_a ? LOAD_B : LOAD_A)
                : state == LOAD_B ? (hs && last_b ? DONE : LOAD_B)
                : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_A <= '0;
      wr_addr_A <= '0;
      wr_data_A <= '0;
      wr_en_B <= '0;
      wr_addr_B <= '0;
      wr_data_B <= '0;
      load_done <= 1'b0;
    end else begin
      wr_en_A <= hs_a ? oh_a : '0;
      wr_en_B <= hs_b ? oh_b : '0;
      if (hs_a) begin
        wr_addr_A <= addr_a;
        wr_data_A <= in_data;
      end
      if (hs_b) begin
        wr_addr_B <= addr_b;
        wr_data_B <= in_data;
      end
      load_done <= state == DONE;
    end
  end
`ifdef LOADER_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) load_err <= 1'b0;
    else if (hs && in_last != (state == LOAD_A ? last_a : last_b)) load_err <= 1'b1;
  end
`else
  logic unused_last;
  always_comb begin
    unused_last = in_last;
    load_err = 1'b0;
  end
`endif
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: randomized scoreboard bench for operand_loader at (N=3,M=6) and (N=2,M=8)
module tb_operand_loader;
  typedef struct {
    int b;
    int bank;
    int addr;
    int data;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic start_v [2];
  logic in_valid_v [2];
  logic rdy0, busy0, ld0, err0, rdy1, busy1, ld1, err1;
  logic [2:0] wea0, web0;
  logic [3:0] waa0, wab0;
  logic [7:0] wda0, wdb0, wda1, wdb1;
  logic [1:0] wea1, web1;
  logic [4:0] waa1, wab1;
  int checks = 0, failures = 0;
  int NP [2] = '{3, 2};
  int MP [2] = '{6, 8};
  int ga [2][64];
  int gb [2][64];
  int mem [2][2][3][32];
  int wcnt [2] = '{0, 0};
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  operand_loader u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data), .in_valid(in_valid_v[0]), .in_last(in_last),
    .in_ready(rdy0), .wr_en_A(wea0), .wr_addr_A(waa0), .wr_data_A(wda0), .wr_en_B(web0), .wr_addr_B(wab0),
    .wr_data_B(wdb0), .busy(busy0), .load_done(ld0), .load_err(err0)
  );
  operand_loader #(.N(2), .M(8), .DATA_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data), .in_valid(in_valid_v[1]), .in_last(in_last),
    .in_ready(rdy1), .wr_en_A(wea1), .wr_addr_A(waa1), .wr_data_A(wda1), .wr_en_B(web1), .wr_addr_B(wab1),
    .wr_data_B(wdb1), .busy(busy1), .load_done(ld1), .load_err(err1)
  );
  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic int code(input int ena, input int enb, input int addr, input int data);
    return (ena << 24) | (enb << 16) | (addr << 8) | data;
  endfunction
  always @(negedge clk) begin
    int ea, eb, aa, ab, da, db, en, ad, dt;
    exp_t x;
    for (int u = 0; u < 2; u++) begin
      ea = u ? int'(wea1) : int'(wea0);
      eb = u ? int'(web1) : int'(web0);
      aa = u ? int'(waa1) : int'(waa0);
      ab = u ? int'(wab1) : int'(wab0);
      da = u ? int'(wda1) : int'(wda0);
      db = u ? int'(wdb1) : int'(wdb0);
      if (ea != 0 || eb != 0) begin
        ad = ea != 0 ? aa : ab;
        dt = ea != 0 ? da : db;
        if ((u ? q1.size() : q0.size()) == 0) chk(1'b0, "unexpected_write", code(ea, eb, ad, dt), 0);
        else begin
          x = u ? q1.pop_front() : q0.pop_front();
          chk(code(ea, eb, ad, dt) == code(x.b ? 0 : 1 << x.bank, x.b ? 1 << x.bank : 0, x.addr, x.data),
              u ? "write_u1" : "write_u0", code(ea, eb, ad, dt),
              code(x.b ? 0 : 1 << x.bank, x.b ? 1 << x.bank : 0, x.addr, x.data));
        end
        for (int m = 0; m < 2; m++) begin
          en = m ? eb : ea;
          for (int b = 0; b < 3; b++) if (en[b]) mem[u][m][b][m ? ab : aa] = m ? db : da;
        end
        wcnt[u]++;
      end
    end
  end
  task automatic run(input int u, input bit gaps, input bit spam, input int rst_at, input int bad_at, input bit fixed);
    int n, m, mm, e, mat, cyc, w0, r, k, c, got, want, err_req;
    exp_t x;
    n = NP[u];
    m = MP[u];
    mm = m * m;
    for (int i = 0; i < mm; i++) begin
      ga[u][i] = fixed ? i : int'($urandom_range(0, 255));
      gb[u][i] = fixed ? 100 + i : int'($urandom_range(0, 255));
    end
    w0 = wcnt[u];
    start_v[u] = 1'b1;
    @(negedge clk);
    start_v[u] = 1'b0;
    chk((u ? err1 : err0) == 1'b0, "load_err_after_start", int'(u ? err1 : err0), 0);
    e = 0;
    mat = 0;
    cyc = 0;
    while (mat < 2) begin
      in_valid_v[u] = !gaps || $urandom_range(0, 2) != 0;
      in_data = 8'(mat ? gb[u][e] : ga[u][e]);
      in_last = (e == mm - 1) ^ (mat == 0 && e == bad_at);
      start_v[u] = spam && $urandom_range(0, 4) == 0;
      chk((u ? rdy1 : rdy0) == 1'b1, "in_ready_loading", int'(u ? rdy1 : rdy0), 1);
      chk((u ? busy1 : busy0) == 1'b1, "busy_loading", int'(u ? busy1 : busy0), 1);
      if (mat == 0 && e == rst_at) begin
        rst = 1'b1;
        in_valid_v[u] = 1'b0;
        start_v[u] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk((u ? rdy1 : rdy0) == 1'b0, "in_ready_after_rst", int'(u ? rdy1 : rdy0), 0);
        return;
      end
      if (in_valid_v[u]) begin
        x.b = mat;
        if (mat == 0) begin
          r = e / m;
          k = e % m;
          x.bank = r % n;
          x.addr = (r / n) * m + k;
        end else begin
          k = e / m;
          c = e % m;
          x.bank = c % n;
          x.addr = (c / n) * m + k;
        end
        x.data = int'(in_data);
        if (u) q1.push_back(x);
        else q0.push_back(x);
        e++;
        if (e == mm) begin
          e = 0;
          mat++;
        end
      end
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        chk(1'b0, "timeout", cyc, 4000);
        in_valid_v[u] = 1'b0;
        start_v[u] = 1'b0;
        return;
      end
    end
    in_valid_v[u] = 1'b0;
    start_v[u] = 1'b0;
    in_last = 1'b0;
    chk((u ? ld1 : ld0) == 1'b0, "load_done_early", int'(u ? ld1 : ld0), 0);
    chk((u ? rdy1 : rdy0) == 1'b0, "in_ready_done", int'(u ? rdy1 : rdy0), 0);
    @(negedge clk);
    chk((u ? ld1 : ld0) == 1'b1, "load_done_pulse", int'(u ? ld1 : ld0), 1);
`ifdef LOADER_LAST_CHECK_EN
    err_req = bad_at >= 0 ? 1 : 0;
`else
    err_req = 0;
`endif
    chk(int'(u ? err1 : err0) == err_req, "load_err", int'(u ? err1 : err0), err_req);
    @(negedge clk);
    chk((u ? ld1 : ld0) == 1'b0, "load_done_single", int'(u ? ld1 : ld0), 0);
    chk((u ? busy1 : busy0) == 1'b0, "busy_idle", int'(u ? busy1 : busy0), 0);
    chk(int'(u ? err1 : err0) == err_req, "load_err_sticky", int'(u ? err1 : err0), err_req);
    chk(wcnt[u] - w0 == 2 * mm, "write_count", wcnt[u] - w0, 2 * mm);
    chk((u ? q1.size() : q0.size()) == 0, "queue_drained", u ? q1.size() : q0.size(), 0);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < m; j++) begin
        got = 0;
        want = 0;
        for (int kk = 0; kk < m; kk++) begin
          got += mem[u][0][i % n][(i / n) * m + kk] * mem[u][1][j % n][(j / n) * m + kk];
          want += ga[u][i * m + kk] * gb[u][kk * m + j];
        end
        chk(got == want, "product", got, want);
      end
  endtask
  initial begin
    start_v = '{1'b0, 1'b0};
    in_valid_v = '{1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk({wea0, web0, waa0, wab0, wda0, wdb0, rdy0, busy0, ld0, err0} == '0, "reset_u0", int'(rdy0), 0);
    chk({wea1, web1, waa1, wab1, wda1, wdb1, rdy1, busy1, ld1, err1} == '0, "reset_u1", int'(rdy1), 0);
    @(negedge clk);
    run(0, 1'b0, 1'b0, -1, -1, 1'b1);
    run(0, 1'b1, 1'b1, -1, -1, 1'b0);
    run(0, 1'b0, 1'b0, 20, -1, 1'b0);
    run(0, 1'b0, 1'b0, -1, -1, 1'b0);
    run(0, 1'b1, 1'b0, -1, 34, 1'b0);
    run(0, 1'b1, 1'b1, -1, -1, 1'b0);
    run(1, 1'b1, 1'b1, -1, -1, 1'b0);
    run(1, 1'b0, 1'b0, -1, -1, 1'b1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
